// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: one-hot FSM encoding and
// address-field width helpers derived from the SETS / LINE_WORDS parameters.
package inst_cache_pkg;

  localparam int STATE_W = 6;

  // One-hot encoding: each state owns exactly one flop bit.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 6'b000001,
    S_LOOKUP   = 6'b000010,
    S_HIT_RSP  = 6'b000100,
    S_MEM_REQ  = 6'b001000,
    S_REFILL   = 6'b010000,
    S_MISS_RSP = 6'b100000
  } state_t;

  // Word-offset field width (starts at address bit 2).
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Set-index field width (directly above the offset).
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag is whatever remains of the 32-bit byte address.
  function automatic int tag_w(input int sets, input int line_words);
    return 32 - 2 - off_w(line_words) - idx_w(sets);
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Direct-mapped storage: per-set valid bit, tag and LINE_WORDS data words.
// One registered read port (valid/tag/word), one word-write port, a tag
// write that also sets valid, a per-set invalidate, and a full valid clear
// on rst. Data and tag arrays are not reset so they map onto block RAM.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [idx_w(SETS)-1:0]                  rd_idx_i,
  input  logic [off_w(LINE_WORDS)-1:0]            rd_off_i,
  output logic                                    rd_valid_o,
  output logic [tag_w(SETS, LINE_WORDS)-1:0]      rd_tag_o,
  output logic [31:0]                             rd_data_o,
  input  logic                                    wr_en_i,
  input  logic [idx_w(SETS)-1:0]                  wr_idx_i,
  input  logic [off_w(LINE_WORDS)-1:0]            wr_off_i,
  input  logic [31:0]                             wr_data_i,
  input  logic                                    tag_wr_en_i,
  input  logic [tag_w(SETS, LINE_WORDS)-1:0]      tag_i,
  input  logic                                    inv_en_i
);

  localparam int OW = off_w(LINE_WORDS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(SETS, LINE_WORDS);

  logic [31:0]    data_mem [SETS*LINE_WORDS];
  logic [TW-1:0]  tag_mem  [SETS];
  logic [SETS-1:0] valid_q;
  logic [31:0]    rd_data_q;
  logic [TW-1:0]  rd_tag_q;
  logic           rd_valid_q;

  // Data words: write on accepted refill beat, registered read.
  always_ff @(posedge clk) begin
    if (wr_en_i) data_mem[{wr_idx_i, wr_off_i}] <= wr_data_i;
    rd_data_q <= data_mem[{rd_idx_i, rd_off_i}];
  end

  // Tags: written once the last beat of a refill lands, registered read.
  always_ff @(posedge clk) begin
    if (tag_wr_en_i) tag_mem[wr_idx_i] <= tag_i;
    rd_tag_q <= tag_mem[rd_idx_i];
  end

  // Valid bits: cleared on reset or refill start, set on refill completion.
  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst) valid_q[gi] <= 1'b0;
        else if (tag_wr_en_i && (wr_idx_i == IW'(gi))) valid_q[gi] <= 1'b1;
        else if (inv_en_i && (wr_idx_i == IW'(gi))) valid_q[gi] <= 1'b0;
      end
    end
  endgenerate

  // Registered valid read, aligned with the tag/data read.
  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= valid_q[rd_idx_i];
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. One outstanding fetch; hits
// answer two cycles after the request, misses burst-refill a full line and
// return the requested word. Define INST_CACHE_PERF_EN to build the
// hit/miss performance counters; otherwise both counter ports read 0.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  input  logic [31:0] cpu_req_addr,
  output logic        cpu_req_ready,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_data,
  input  logic        cpu_rsp_ready,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_last,
  output logic        mem_rsp_ready,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
);

  localparam int OW = off_w(LINE_WORDS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(SETS, LINE_WORDS);

  state_t         state_q;
  logic [29:0]    addr_q;      // latched word address (byte bits dropped)
  logic [31:0]    rsp_q;
  logic [OW-1:0]  beat_q;

  logic [29:0]    req_word;
  logic [OW-1:0]  off_q;
  logic [IW-1:0]  idx_q;
  logic [TW-1:0]  tag_q;
  logic [IW-1:0]  rd_idx;
  logic [OW-1:0]  rd_off;
  logic           rd_valid;
  logic [TW-1:0]  rd_tag;
  logic [31:0]    rd_data;
  logic           lookup_hit;
  logic           beat_acc;
  logic           unused_addr_bits;

  assign req_word         = cpu_req_addr[31:2];
  assign unused_addr_bits = ^cpu_req_addr[1:0];
  assign off_q = addr_q[OW-1:0];
  assign idx_q = addr_q[OW+IW-1:OW];
  assign tag_q = addr_q[29:OW+IW];

  // Read the arrays with the incoming address while idle so the registered
  // read is ready for the tag compare in LOOKUP.
  assign rd_idx = (state_q == S_IDLE) ? req_word[OW+IW-1:OW] : idx_q;
  assign rd_off = (state_q == S_IDLE) ? req_word[OW-1:0]     : off_q;

  assign lookup_hit = rd_valid && (rd_tag == tag_q);
  assign beat_acc   = (state_q == S_REFILL) && mem_rsp_valid;

  inst_cache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (rd_idx),
    .rd_off_i    (rd_off),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (beat_acc),
    .wr_idx_i    (idx_q),
    .wr_off_i    (beat_q),
    .wr_data_i   (mem_rsp_data),
    .tag_wr_en_i (beat_acc && mem_rsp_last),
    .tag_i       (tag_q),
    .inv_en_i    ((state_q == S_MEM_REQ) && mem_req_ready)
  );

  // Fetch FSM with the latched address, beat counter and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rsp_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req_valid) begin
            addr_q  <= req_word;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            rsp_q   <= rd_data;
            state_q <= S_HIT_RSP;
          end else begin
            state_q <= S_MEM_REQ;
          end
        end
        S_HIT_RSP: begin
          if (cpu_rsp_ready) state_q <= S_IDLE;
        end
        S_MEM_REQ: begin
          if (mem_req_ready) begin
            beat_q  <= '0;
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_rsp_valid) begin
            beat_q <= beat_q + OW'(1);
            if (beat_q == off_q) rsp_q <= mem_rsp_data;
            if (mem_rsp_last) state_q <= S_MISS_RSP;
          end
        end
        S_MISS_RSP: begin
          if (cpu_rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_req_ready = (state_q == S_IDLE);
  assign cpu_rsp_valid = (state_q == S_HIT_RSP) || (state_q == S_MISS_RSP);
  assign cpu_rsp_data  = rsp_q;
  assign mem_req_valid = (state_q == S_MEM_REQ);
  assign mem_req_addr  = {tag_q, idx_q, {(OW + 2){1'b0}}};
  assign mem_rsp_ready = (state_q == S_REFILL);

`ifdef INST_CACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Count lookup outcomes; counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else            miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the multi-cycle CPU's instruction request/response channels and the memory-side read port. Each CPU fetch is one request handshake (PC) followed by one response handshake (instruction word). Hits return from on-chip arrays. Misses fetch a full line as a burst from memory, then return the requested word.

## Interface
Parameters:
- SETS, 8, number of lines; power of two.
- LINE_WORDS, 8, 32-bit words per line; power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req_valid  in  1  CPU fetch request (PC valid)
- cpu_req_addr  in  32  fetch address; bits [1:0] ignored
- cpu_req_ready  out  1  cache accepts request
- cpu_rsp_valid  out  1  instruction word valid
- cpu_rsp_data  out  32  instruction word
- cpu_rsp_ready  in  1  CPU accepts word
- mem_req_valid  out  1  line read request
- mem_req_addr  out  32  line-aligned address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  burst beat valid
- mem_rsp_data  in  32  burst beat
- mem_rsp_last  in  1  final beat of burst
- mem_rsp_ready  out  1  cache accepts beat
- perf_hit_cnt  out  32  hit counter
- perf_miss_cnt  out  32  miss counter

## Operation
Address split (defaults):
- offset = addr[4:2]
- index = addr[7:5]
- tag = addr[31:8]
- General form: offset is log2(LINE_WORDS) bits starting at bit 2; index follows; tag is the remainder.

Storage: per set, a valid bit, a tag and LINE_WORDS data words.

One-hot FSM:
- IDLE: cpu_req_ready=1. On cpu_req_valid, latch the address and go to LOOKUP.
- LOOKUP: compare the tag. On a hit (valid set and tag equal), go to HIT_RSP. On a miss, go to MEM_REQ.
- HIT_RSP: cpu_rsp_valid=1 and cpu_rsp_data is the cached word. On cpu_rsp_ready, go to IDLE.
- MEM_REQ: mem_req_valid=1, mem_req_addr = {latched tag, index, offset zeroed}. On mem_req_ready, go to REFILL and clear the beat counter.
- REFILL: mem_rsp_ready=1.
  - Each accepted beat is written to data word [beat counter], then the counter increments.
  - The beat whose counter equals the latched offset is also captured into the response register.
  - On an accepted beat with mem_rsp_last, write the tag, set valid, and go to MISS_RSP.
- MISS_RSP: cpu_rsp_valid=1 with the captured word. On cpu_rsp_ready, go to IDLE.

Rules:
- Only one outstanding fetch; cpu_req_ready is 0 outside IDLE.
- The valid bit is cleared when REFILL is entered, so a partially refilled line is never hit.
- Beats beyond LINE_WORDS before last: the counter wraps and later beats overwrite earlier ones. Memory guarantees exactly LINE_WORDS beats.
- Outputs are held stable while valid and not yet accepted.

## Timing
- Reset: state IDLE, all valid bits 0, every output 0 except cpu_req_ready=1; both perf counters 0. Arrays other than valid bits are not reset.
- A reset during REFILL or MEM_REQ abandons the transfer. The memory side shares rst and drops its burst.
- Hit latency: request accepted at cycle t, cpu_rsp_valid at t+2.
- Miss latency: mem_req_valid at t+2; cpu_rsp_valid one cycle after the last beat is accepted.
- A request accepted in the same cycle the previous response was accepted is impossible, because cpu_req_ready is only 1 in IDLE. Back-to-back fetch throughput on hits is therefore one per 3 cycles.

## Configuration
- INST_CACHE_PERF_EN defined:
  - perf_hit_cnt increments on each LOOKUP→HIT_RSP transition.
  - perf_miss_cnt increments on each LOOKUP→MEM_REQ transition.
  - Both are 32-bit and wrap at 2^32.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Structure
- Package inst_cache_pkg holds:
  - one-hot state localparams (S_IDLE, S_LOOKUP, S_HIT_RSP, S_MEM_REQ, S_REFILL, S_MISS_RSP)
  - offset/index/tag width functions derived from SETS and LINE_WORDS
- Sub-module inst_cache_array: valid, tag and data storage with one read port and one word-write port, plus synchronous valid clear on rst.

## Test plan
- Cold fetch 0x0000_0104 → mem_req_addr=0x0000_0100. Beats 0x100..0x11C carry words W0..W7 → cpu_rsp_data=W1; perf_miss_cnt=1.
- Refetch 0x0000_0108 → no mem_req_valid; cpu_rsp_data=W2 at t+2; perf_hit_cnt=1.
- Fetch 0x0000_0200 (same index, different tag) → miss, refill from 0x200. A subsequent fetch of 0x0000_0104 misses again.
- Stall: mem_req_ready low 5 cycles, mem_rsp_valid gapped, cpu_rsp_ready low 3 cycles → all outputs held stable; correct word delivered once.
- rst asserted mid-REFILL after 3 beats → IDLE next cycle. Refetch 0x0000_0104 misses, with no hit on the stale line.
- Build without INST_CACHE_PERF_EN → the same sequences work and both counters read 0.
